vfp_addsub_sequencer: RTL
=========================

// Module: vfp_addsub_sequencer
// PURPOSE
//  Issue-side controller for the vector FP add/sub unit. Accepts one vector add/sub
//  request, reads the vs1/vs2 register groups one 128-bit row at a time, drives each
//  row into the FP unit, waits for the unit's done, and writes the vd row back with tail
//  byte-enables. One request is in flight at a time. Sits between vector issue and the FU.
// PARAMETERS
//  VRF_AW          5   VRF row address width (128-bit rows)
//  VL_W            8   width of element-count field
//  TIMEOUT_CYCLES  16  max WAIT cycles before abort (VFP_SEQ_TIMEOUT_EN only)
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        reset, asynchronous, active-low
//  req_valid_i    in   1        request valid
//  req_ready_o    out  1        high only in IDLE; request accepted on valid&ready
//  req_add_sub_i  in   1        0 add, 1 sub
//  req_vsew_i     in   2        2'b10 32-bit, 2'b11 64-bit; others illegal
//  req_vl_i       in   VL_W     element count
//  req_vs1_base_i / req_vs2_base_i / req_vd_base_i  in  VRF_AW  base rows
//  rd_en_o        out  1        VRF read strobe; data returns next cycle
//  rd_addr1_o / rd_addr2_o     out  VRF_AW  vs1/vs2 row addresses
//  rd_data1_i / rd_data2_i     in   128     row data, valid 1 cycle after rd_en_o
//  fu_add_sub_o   out  1        to FU add_sub_i
//  fu_vsew_o      out  2        to FU vsew_i; 2'b00 = NOP
//  fu_vs1_o / fu_vs2_o         out  128     registered operands to FU
//  fu_done_i      in   1        FU result valid
//  fu_vd_i        in   128      FU result, sampled when fu_done_i=1
//  wr_en_o        out  1        VRF write strobe (one cycle per row)
//  wr_addr_o      out  VRF_AW   vd row address
//  wr_data_o      out  128      write data
//  wr_be_o        out  16       byte enables
//  busy_o         out  1        high in any state except IDLE
//  done_o         out  1        one-cycle pulse at request completion
//  err_o          out  1        one-cycle pulse with done_o on error
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except req_ready_o=1; fu_vsew_o=2'b00; counters 0.
//    Reset mid-operation discards the request; no further rd/wr strobes.
//  - Element 0 in bits [31:0]/[63:0]. EPC = 4 (32b) or 2 (64b); rows = ceil(VL/EPC).
//  - FSM: IDLE -> READ on accept (latch op, vsew, VL, bases; idx=0).
//    VL=0: IDLE -> DONE, no rd/wr. Illegal vsew: IDLE -> DONE with err_o, no rd/wr.
//    READ (1 cyc): rd_en_o=1, rd_addrN_o = baseN+idx mod 2^VRF_AW.
//    ISSUE (1 cyc): register rd_data into fu_vs1_o/fu_vs2_o; fu_vsew_o=vsew,
//      fu_add_sub_o=op; both held through WAIT.
//    WAIT: stay until fu_done_i=1; capture fu_vd_i that cycle.
//    WRITE (1 cyc): fu_vsew_o=2'b00 (NOP, so the FU sees a fresh op next row);
//      wr_en_o=1, wr_addr_o = vd_base+idx (wraps), wr_data_o = captured result.
//      wr_be_o=16'hFFFF, except last row with r=VL-idx*EPC<EPC:
//      be=(1<<(r*4))-1 for 32b, (1<<(r*8))-1 for 64b. idx++; last row -> DONE, else READ.
//    DONE (1 cyc): done_o=1 (err_o if flagged), -> IDLE.
//  - Per-row latency: 3 cycles + FU latency. fu_done_i outside WAIT is ignored.
//  - req_valid_i while busy is not accepted (ready=0); no queueing.
// CONFIGURATION
//  VFP_SEQ_TIMEOUT_EN defined: WAIT counter; reaching TIMEOUT_CYCLES without fu_done_i
//    -> DONE with err_o=1; that row not written; fu_vsew_o=2'b00. Counter clears per row.
//  Undefined: no counter; WAIT holds indefinitely; err_o only for illegal vsew.
// TESTING
//  1 32b add VL=8, vs1=0,vs2=4,vd=8, all lanes 0x3F800000+0x40000000 -> wr rows 8,9,
//    data 4x0x40400000, be FFFF, one done_o, err_o=0.
//  2 64b sub VL=3, vd_base=31 -> writes row 31 (be FFFF) then row 0 (be 00FF); done_o.
//  3 VL=0 -> done_o 2 cycles after accept, rd_en_o/wr_en_o never high.
//  4 vsew=2'b01 -> done_o&err_o, no VRF access; next legal request completes normally.
//  5 rst_ni low during WAIT -> outputs at reset values immediately; new request OK.
//  6 fu_done_i held 0: with macro err_o&done_o after 16 WAIT cycles, no write;
//    without macro busy_o stays 1 for 100 cycles.

Source files
------------

// File: rtl/vfp_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// vfp_addsub_sequencer
//
// Issue-side controller for the vector FP add/sub unit. One request is taken
// at a time. For each 128-bit row it reads the vs1/vs2 rows, presents them to
// the FP unit, waits for the unit's done, and writes the vd row back. On the
// last row the write carries tail byte-enables.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_*                            request handshake and fields
//                                    (op, vsew, vl, three base rows)
//   rd_en_o, rd_addr1_o/2_o          VRF read port (data returns next cycle)
//   rd_data1_i/2_i                   VRF read data
//   fu_add_sub_o, fu_vsew_o          FU op / element width (2'b00 = NOP)
//   fu_vs1_o/fu_vs2_o                registered FU operands
//   fu_done_i, fu_vd_i               FU result handshake and data
//   wr_en_o, wr_addr_o, wr_data_o,   VRF write port, one strobe per row
//   wr_be_o
//   busy_o, done_o, err_o            status; done_o/err_o are one-cycle pulses
//
// Optional feature: define VFP_SEQ_TIMEOUT_EN to abort a row that waits
// TIMEOUT_CYCLES cycles without fu_done_i. The row is not written, and the
// request ends with done_o and err_o.
// -----------------------------------------------------------------------------
module vfp_addsub_sequencer #(
  parameter int VRF_AW = 5,
  parameter int VL_W   = 8
`ifdef VFP_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_add_sub_i,
  input  logic [1:0]        req_vsew_i,
  input  logic [VL_W-1:0]   req_vl_i,
  input  logic [VRF_AW-1:0] req_vs1_base_i,
  input  logic [VRF_AW-1:0] req_vs2_base_i,
  input  logic [VRF_AW-1:0] req_vd_base_i,
  output logic              rd_en_o,
  output logic [VRF_AW-1:0] rd_addr1_o,
  output logic [VRF_AW-1:0] rd_addr2_o,
  input  logic [127:0]      rd_data1_i,
  input  logic [127:0]      rd_data2_i,
  output logic              fu_add_sub_o,
  output logic [1:0]        fu_vsew_o,
  output logic [127:0]      fu_vs1_o,
  output logic [127:0]      fu_vs2_o,
  input  logic              fu_done_i,
  input  logic [127:0]      fu_vd_i,
  output logic              wr_en_o,
  output logic [VRF_AW-1:0] wr_addr_o,
  output logic [127:0]      wr_data_o,
  output logic [15:0]       wr_be_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_r;
  logic                op_r;
  logic [1:0]          vsew_r;
  logic [VL_W-1:0]     rem_r;       // elements still to be written, incl. current row
  logic [VRF_AW-1:0]   vs1_base_r;
  logic [VRF_AW-1:0]   vs2_base_r;
  logic [VRF_AW-1:0]   vd_base_r;
  logic [VRF_AW-1:0]   idx_r;       // row index; only ever used modulo the VRF size
  logic                req_ready_r;
  logic                rd_en_r;
  logic [VRF_AW-1:0]   rd_addr1_r;
  logic [VRF_AW-1:0]   rd_addr2_r;
  logic                fu_add_sub_r;
  logic [1:0]          fu_vsew_r;
  logic [127:0]        fu_vs1_r;
  logic [127:0]        fu_vs2_r;
  logic                wr_en_r;
  logic [VRF_AW-1:0]   wr_addr_r;
  logic [127:0]        wr_data_r;
  logic [15:0]         wr_be_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic [VL_W-1:0]     epc_s;       // elements per 128-bit row
`ifdef VFP_SEQ_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         wait_cnt_r;
`endif

  // vsew_r[0] separates 64-bit (2'b11) from 32-bit (2'b10) once legality is known.
  assign epc_s = vsew_r[0] ? VL_W'(2) : VL_W'(4);

  // Byte-enables for a row holding `rem` remaining elements; only a partial
  // last row (rem < elements per row) gets a narrower mask.
  function automatic logic [15:0] tail_be(input logic [VL_W-1:0] rem, input logic is64);
    logic [15:0] be;
    be = 16'hFFFF;
    if (is64) begin
      if (rem < VL_W'(2)) be = 16'h00FF;
      else                be = 16'hFFFF;
    end else begin
      case (rem)
        VL_W'(1): be = 16'h000F;
        VL_W'(2): be = 16'h00FF;
        VL_W'(3): be = 16'h0FFF;
        default:  be = 16'hFFFF;
      endcase
    end
    return be;
  endfunction

  // Request FSM with all outputs registered on the transition into each state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= S_IDLE;
      op_r         <= 1'b0;
      vsew_r       <= 2'b00;
      rem_r        <= {VL_W{1'b0}};
      vs1_base_r   <= {VRF_AW{1'b0}};
      vs2_base_r   <= {VRF_AW{1'b0}};
      vd_base_r    <= {VRF_AW{1'b0}};
      idx_r        <= {VRF_AW{1'b0}};
      req_ready_r  <= 1'b1;
      rd_en_r      <= 1'b0;
      rd_addr1_r   <= {VRF_AW{1'b0}};
      rd_addr2_r   <= {VRF_AW{1'b0}};
      fu_add_sub_r <= 1'b0;
      fu_vsew_r    <= 2'b00;
      fu_vs1_r     <= 128'd0;
      fu_vs2_r     <= 128'd0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {VRF_AW{1'b0}};
      wr_data_r    <= 128'd0;
      wr_be_r      <= 16'h0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef VFP_SEQ_TIMEOUT_EN
      wait_cnt_r   <= 16'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid_i && req_ready_r) begin
            op_r        <= req_add_sub_i;
            vsew_r      <= req_vsew_i;
            rem_r       <= req_vl_i;
            vs1_base_r  <= req_vs1_base_i;
            vs2_base_r  <= req_vs2_base_i;
            vd_base_r   <= req_vd_base_i;
            idx_r       <= {VRF_AW{1'b0}};
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            // Only 2'b10 / 2'b11 are legal widths; bit 1 clear means illegal.
            if (!req_vsew_i[1]) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
            end else if (req_vl_i == {VL_W{1'b0}}) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= S_READ;
              rd_en_r    <= 1'b1;
              rd_addr1_r <= req_vs1_base_i;
              rd_addr2_r <= req_vs2_base_i;
            end
          end
        end
        S_READ: begin
          rd_en_r      <= 1'b0;
          fu_vsew_r    <= vsew_r;
          fu_add_sub_r <= op_r;
          state_r      <= S_ISSUE;
        end
        S_ISSUE: begin
          // Read data is valid in this cycle only.
          fu_vs1_r <= rd_data1_i;
          fu_vs2_r <= rd_data2_i;
          state_r  <= S_WAIT;
`ifdef VFP_SEQ_TIMEOUT_EN
          wait_cnt_r <= 16'd0;
`endif
        end
        S_WAIT: begin
          if (fu_done_i) begin
            // Dropping vsew to NOP lets the FU see a fresh op on the next row.
            fu_vsew_r <= 2'b00;
            wr_en_r   <= 1'b1;
            wr_addr_r <= vd_base_r + idx_r;
            wr_data_r <= fu_vd_i;
            wr_be_r   <= tail_be(rem_r, vsew_r[0]);
            state_r   <= S_WRITE;
`ifdef VFP_SEQ_TIMEOUT_EN
          end else if (wait_cnt_r == WAIT_LAST) begin
            fu_vsew_r <= 2'b00;
            done_r    <= 1'b1;
            err_r     <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
`endif
          end
        end
        S_WRITE: begin
          wr_en_r <= 1'b0;
          idx_r   <= idx_r + VRF_AW'(1);
          rem_r   <= rem_r - epc_s;
          if (rem_r <= epc_s) begin
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            rd_en_r    <= 1'b1;
            rd_addr1_r <= vs1_base_r + idx_r + VRF_AW'(1);
            rd_addr2_r <= vs2_base_r + idx_r + VRF_AW'(1);
            state_r    <= S_READ;
          end
        end
        S_DONE: begin
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          rd_en_r     <= 1'b0;
          wr_en_r     <= 1'b0;
          fu_vsew_r   <= 2'b00;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_r;
  assign rd_en_o      = rd_en_r;
  assign rd_addr1_o   = rd_addr1_r;
  assign rd_addr2_o   = rd_addr2_r;
  assign fu_add_sub_o = fu_add_sub_r;
  assign fu_vsew_o    = fu_vsew_r;
  assign fu_vs1_o     = fu_vs1_r;
  assign fu_vs2_o     = fu_vs2_r;
  assign wr_en_o      = wr_en_r;
  assign wr_addr_o    = wr_addr_r;
  assign wr_data_o    = wr_data_r;
  assign wr_be_o      = wr_be_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;

endmodule
